mem_access_unit: RTL and testbench

- MEM-stage data-memory access controller for the MIPS pipeline.
- Sits downstream of the store byte-lane selector. Consumes the ALU op code, the effective address, the byte-enable and the pre-shifted store data.
- Runs an SRAM-like request/addr_ok/data_ok transaction to data memory and stalls the pipeline until it completes.
- Returns sign- or zero-extended load data, and flags misaligned accesses as AdEL/AdES without touching the bus.

---
 rtl/mem_access_unit.sv | 167 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: runs one SRAM-like request/addr_ok/data_ok
// transaction per memory op, stalls the pipeline meanwhile and returns extended load data.
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid_i,
    input  logic [7:0]        alu_control_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [3:0]        sel_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              flush_i,
    output logic              data_req_o,
    output logic              data_wr_o,
    output logic [3:0]        data_sel_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [DATA_W-1:0] data_wdata_o,
    input  logic              data_addr_ok_i,
    input  logic              data_data_ok_i,
    input  logic [DATA_W-1:0] data_rdata_i,
    output logic              stall_o,
    output logic              load_valid_o,
    output logic [DATA_W-1:0] load_data_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic [ADDR_W-1:0] badvaddr_o
);

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_q;
    logic        cancel_q;
    logic [7:0]  op_q;
    logic [1:0]  offset_q;

    logic        isLoad;
    logic        isStore;
    logic        isHalf;
    logic        isWord;
    logic        misaligned;
    logic        idleValid;
    logic        issue;
    logic        busy;
    logic        complete;
    logic        deliverLoad;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic [DATA_W-1:0] loadExt_d;

    always_comb begin
        isLoad  = 1'b0;
        isStore = 1'b0;
        isHalf  = 1'b0;
        isWord  = 1'b0;
        case (alu_control_i)
            EXE_LB_OP, EXE_LBU_OP: isLoad = 1'b1;
            EXE_LH_OP, EXE_LHU_OP: begin isLoad = 1'b1; isHalf = 1'b1; end
            EXE_LW_OP:             begin isLoad = 1'b1; isWord = 1'b1; end
            EXE_SB_OP:             isStore = 1'b1;
            EXE_SH_OP:             begin isStore = 1'b1; isHalf = 1'b1; end
            EXE_SW_OP:             begin isStore = 1'b1; isWord = 1'b1; end
            default: ;
        endcase
    end

    assign misaligned = (isHalf & addr_i[0]) | (isWord & (addr_i[1:0] != 2'b00));
    assign idleValid  = (state_q == IDLE) & mem_valid_i & ~flush_i;
    assign issue      = idleValid & (isLoad | isStore) & ~misaligned;
    assign adel_o     = idleValid & isLoad & misaligned;
    assign ades_o     = idleValid & isStore & misaligned;
    assign badvaddr_o = (adel_o | ades_o) ? addr_i : '0;

    // Once cancelled, the old access no longer stalls, but a fresh memory op must wait for IDLE
    assign busy    = (state_q == REQ) | (state_q == WAIT);
    assign stall_o = issue | (busy & ~cancel_q)
                   | (cancel_q & (state_q != IDLE) & mem_valid_i & (isLoad | isStore));

    assign complete    = ((state_q == REQ) & data_addr_ok_i & data_data_ok_i)
                       | ((state_q == WAIT) & data_data_ok_i);
    assign deliverLoad = complete & ~data_wr_o & ~cancel_q & ~flush_i;

    // Big-endian lanes: offset 00 is the most significant byte
    always_comb begin
        byteSel   = 8'h00;
        halfSel   = offset_q[1] ? data_rdata_i[15:0] : data_rdata_i[31:16];
        loadExt_d = data_rdata_i;
        case (offset_q)
            2'b00: byteSel = data_rdata_i[31:24];
            2'b01: byteSel = data_rdata_i[23:16];
            2'b10: byteSel = data_rdata_i[15:8];
            2'b11: byteSel = data_rdata_i[7:0];
            default: ;
        endcase
        case (op_q)
            EXE_LB_OP:  loadExt_d = {{24{byteSel[7]}}, byteSel};
            EXE_LBU_OP: loadExt_d = {24'h000000, byteSel};
            EXE_LH_OP:  loadExt_d = {{16{halfSel[15]}}, halfSel};
            EXE_LHU_OP: loadExt_d = {16'h0000, halfSel};
            default:    loadExt_d = data_rdata_i;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cancel_q     <= 1'b0;
            op_q         <= 8'h00;
            offset_q     <= 2'b00;
            data_req_o   <= 1'b0;
            data_wr_o    <= 1'b0;
            data_sel_o   <= 4'b0000;
            data_addr_o  <= '0;
            data_wdata_o <= '0;
            load_valid_o <= 1'b0;
            load_data_o  <= '0;
        end else begin
            load_valid_o <= 1'b0;
            if (deliverLoad) begin
                load_valid_o <= 1'b1;
                load_data_o  <= loadExt_d;
            end
            case (state_q)
                IDLE: begin
                    cancel_q <= 1'b0;
                    if (issue) begin
                        state_q      <= REQ;
                        data_req_o   <= 1'b1;
                        data_wr_o    <= isStore;
                        data_sel_o   <= isStore ? sel_i : 4'b1111;
                        data_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                        data_wdata_o <= isStore ? wdata_i : '0;
                        op_q         <= alu_control_i;
                        offset_q     <= addr_i[1:0];
                    end
                end
                REQ: begin
                    if (flush_i) cancel_q <= 1'b1;
                    if (data_addr_ok_i) begin
                        data_req_o <= 1'b0;
                        state_q    <= data_data_ok_i ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (flush_i) cancel_q <= 1'b1;
                    if (data_data_ok_i) state_q <= DONE;
                end
                DONE: begin
                    state_q  <= IDLE;
                    cancel_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stimulus pushes expected bus requests and load
// results into queues, a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_access_unit;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    typedef struct packed {
        logic        wr;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } busTxn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i;
    logic [7:0]  alu_control_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] wdata_i;
    logic        flush_i;
    logic        data_req_o;
    logic        data_wr_o;
    logic [3:0]  data_sel_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_addr_ok_i;
    logic        data_data_ok_i;
    logic [31:0] data_rdata_i;
    logic        stall_o;
    logic        load_valid_o;
    logic [31:0] load_data_o;
    logic        adel_o;
    logic        ades_o;
    logic [31:0] badvaddr_o;

    int vectors = 0;
    int miscompares = 0;
    busTxn_t     busQ[$];
    logic [31:0] loadQ[$];

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid_i), .alu_control_i(alu_control_i), .addr_i(addr_i),
        .sel_i(sel_i), .wdata_i(wdata_i), .flush_i(flush_i),
        .data_req_o(data_req_o), .data_wr_o(data_wr_o), .data_sel_o(data_sel_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_addr_ok_i(data_addr_ok_i), .data_data_ok_i(data_data_ok_i),
        .data_rdata_i(data_rdata_i), .stall_o(stall_o), .load_valid_o(load_valid_o),
        .load_data_o(load_data_o), .adel_o(adel_o), .ades_o(ades_o), .badvaddr_o(badvaddr_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: bus requests are checked on the accepting cycle, loads on their pulse
    always @(negedge clk) begin
        if (!rst && load_valid_o) begin
            if (loadQ.size() == 0) checkOutput("spurious load_valid", {31'b0, load_valid_o}, 32'h0);
            else checkOutput("load_data", load_data_o, loadQ.pop_front());
        end
        if (!rst && data_req_o && data_addr_ok_i) begin
            if (busQ.size() == 0) checkOutput("spurious bus request", {31'b0, data_req_o}, 32'h0);
            else begin
                busTxn_t e;
                e = busQ.pop_front();
                checkOutput("bus wr", {31'b0, data_wr_o}, {31'b0, e.wr});
                checkOutput("bus sel", {28'b0, data_sel_o}, {28'b0, e.sel});
                checkOutput("bus addr", data_addr_o, e.addr);
                checkOutput("bus wdata", data_wdata_o, e.wdata);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] op, input logic [31:0] addr, input logic [3:0] sel,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int addrWait, input int dataGap, input bit isLoad,
                                 input logic [31:0] expData, input bit flushInWait);
        mem_valid_i = 1'b1; alu_control_i = op; addr_i = addr; sel_i = sel; wdata_i = wdata;
        busQ.push_back('{wr: !isLoad, sel: isLoad ? 4'hF : sel,
                         addr: {addr[31:2], 2'b00}, wdata: isLoad ? 32'h0 : wdata});
        if (isLoad && !flushInWait) loadQ.push_back(expData);
        @(negedge clk);
        checkOutput("issue stall", {31'b0, stall_o}, 32'h1);
        checkOutput("issue faults", {30'b0, adel_o, ades_o}, 32'h0);
        @(posedge clk); #1;
        for (int i = 0; i < addrWait; i++) begin
            @(negedge clk);
            checkOutput("req held", {31'b0, data_req_o}, 32'h1);
            checkOutput("req stall", {31'b0, stall_o}, 32'h1);
            @(posedge clk); #1;
        end
        data_addr_ok_i = 1'b1;
        data_rdata_i   = rdata;
        if (dataGap == 0) data_data_ok_i = 1'b1;
        @(negedge clk);
        checkOutput("addr_ok stall", {31'b0, stall_o}, 32'h1);
        @(posedge clk); #1;
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0;
        if (dataGap > 0) begin
            for (int i = 1; i < dataGap; i++) begin
                if (flushInWait && i == 1) begin flush_i = 1'b1; mem_valid_i = 1'b0; end
                @(negedge clk);
                checkOutput("wait req low", {31'b0, data_req_o}, 32'h0);
                checkOutput("wait stall", {31'b0, stall_o}, (flushInWait && i > 1) ? 32'h0 : 32'h1);
                @(posedge clk); #1;
                flush_i = 1'b0;
            end
            data_data_ok_i = 1'b1;
            @(negedge clk);
            checkOutput("data_ok stall", {31'b0, stall_o}, flushInWait ? 32'h0 : 32'h1);
            @(posedge clk); #1;
            data_data_ok_i = 1'b0;
        end
        @(negedge clk);
        checkOutput("done stall", {31'b0, stall_o}, 32'h0);
        @(posedge clk); #1;
        mem_valid_i = 1'b0; alu_control_i = OP_NOP;
        @(negedge clk);
        checkOutput("idle req", {31'b0, data_req_o}, 32'h0);
        checkOutput("load queue drained", loadQ.size(), 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; mem_valid_i = 1'b0; alu_control_i = OP_NOP; addr_i = '0; sel_i = '0;
        wdata_i = '0; flush_i = 1'b0; data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0; data_rdata_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset req", {31'b0, data_req_o}, 32'h0);
        checkOutput("reset stall", {31'b0, stall_o}, 32'h0);
        checkOutput("reset load_data", load_data_o, 32'h0);
        checkOutput("reset addr", data_addr_o, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] loads");
        applyStimulus(OP_LB,  32'h1000_0001, 4'h0, 32'h0, 32'h12F4_5678, 1, 2, 1, 32'hFFFF_FFF4, 0);
        applyStimulus(OP_LHU, 32'h1000_0002, 4'h0, 32'h0, 32'hAAAA_8001, 0, 1, 1, 32'h0000_8001, 0);
        applyStimulus(OP_LBU, 32'h1000_0003, 4'h0, 32'h0, 32'h12F4_5678, 0, 1, 1, 32'h0000_0078, 0);
        applyStimulus(OP_LH,  32'h1000_0000, 4'h0, 32'h0, 32'h8001_1234, 0, 1, 1, 32'hFFFF_8001, 0);
        applyStimulus(OP_LH,  32'h1000_0002, 4'h0, 32'h0, 32'hAAAA_8001, 0, 1, 1, 32'hFFFF_8001, 0);

        $display("[TB] stores");
        applyStimulus(OP_SB, 32'h2000_0000, 4'b1000, 32'h5A00_0000, 32'h0, 3, 1, 0, 32'h0, 0);
        checkOutput("load_data hold", load_data_o, 32'hFFFF_8001);
        applyStimulus(OP_SW, 32'h2000_0004, 4'b1111, 32'hCAFE_F00D, 32'h0, 0, 2, 0, 32'h0, 0);

        $display("[TB] alignment faults and non-memory ops");
        mem_valid_i = 1'b1; alu_control_i = OP_LW; addr_i = 32'h0000_0006;
        @(negedge clk);
        checkOutput("LW adel", {31'b0, adel_o}, 32'h1);
        checkOutput("LW ades", {31'b0, ades_o}, 32'h0);
        checkOutput("LW badvaddr", badvaddr_o, 32'h0000_0006);
        checkOutput("LW fault stall", {31'b0, stall_o}, 32'h0);
        @(posedge clk); #1;
        alu_control_i = OP_SH; addr_i = 32'h4000_0001;
        @(negedge clk);
        checkOutput("SH ades", {31'b0, ades_o}, 32'h1);
        checkOutput("SH adel", {31'b0, adel_o}, 32'h0);
        checkOutput("SH badvaddr", badvaddr_o, 32'h4000_0001);
        checkOutput("LW fault no req", {31'b0, data_req_o}, 32'h0);
        @(posedge clk); #1;
        alu_control_i = OP_LW; addr_i = 32'h0000_0006; flush_i = 1'b1;
        @(negedge clk);
        checkOutput("flushed fault adel", {31'b0, adel_o}, 32'h0);
        checkOutput("flushed badvaddr", badvaddr_o, 32'h0);
        checkOutput("SH fault no req", {31'b0, data_req_o}, 32'h0);
        @(posedge clk); #1;
        flush_i = 1'b0; alu_control_i = OP_ADD;
        @(negedge clk);
        checkOutput("non-mem stall", {31'b0, stall_o}, 32'h0);
        @(posedge clk); #1;
        mem_valid_i = 1'b0; alu_control_i = OP_NOP;
        @(negedge clk);
        checkOutput("non-mem no req", {31'b0, data_req_o}, 32'h0);
        @(posedge clk); #1;

        $display("[TB] flush during WAIT, then same-cycle completion");
        applyStimulus(OP_LW, 32'h1000_0010, 4'h0, 32'h0, 32'h1111_1111, 0, 3, 1, 32'h0, 1);
        applyStimulus(OP_LW, 32'h1000_0008, 4'h0, 32'h0, 32'hDEAD_BEEF, 0, 0, 1, 32'hDEAD_BEEF, 0);

        $display("[TB] async reset mid-REQ");
        mem_valid_i = 1'b1; alu_control_i = OP_SW; addr_i = 32'h3000_0004;
        sel_i = 4'b1111; wdata_i = 32'hCAFE_F00D;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("pre-reset req", {31'b0, data_req_o}, 32'h1);
        checkOutput("pre-reset addr", data_addr_o, 32'h3000_0004);
        #2;
        rst = 1'b1; mem_valid_i = 1'b0; alu_control_i = OP_NOP;
        #1;
        checkOutput("async req drop", {31'b0, data_req_o}, 32'h0);
        checkOutput("async stall", {31'b0, stall_o}, 32'h0);
        checkOutput("async wr", {31'b0, data_wr_o}, 32'h0);
        checkOutput("async sel", {28'b0, data_sel_o}, 32'h0);
        checkOutput("async addr", data_addr_o, 32'h0);
        checkOutput("async wdata", data_wdata_o, 32'h0);
        checkOutput("async load_data", load_data_o, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset req", {31'b0, data_req_o}, 32'h0);
        applyStimulus(OP_LBU, 32'h1000_0000, 4'h0, 32'h0, 32'h8899_AABB, 0, 1, 1, 32'h0000_0088, 0);

        checkOutput("load queue empty", loadQ.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
